tagger_evt_fifo: RTL

//  N-channel, single-clock time tagger. Replaces the single-event memory with an event FIFO so pile-up is buffered rather than lost.

---
 rtl/tagger_pkg.sv | 19 +
 rtl/tagger_sync_fifo.sv | 61 ++++++
 rtl/tagger_evt_fifo.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/tagger_pkg.sv
// Shared constants for the event-FIFO time tagger: record layout helpers,
// synchroniser depth and the width of the lost-trigger counter.
package tagger_pkg;

    localparam int unsigned TS_LSB     = 0;
    localparam int unsigned SYNC_DEPTH = 2;
    localparam int unsigned LOST_W     = 16;

    // Each channel field is {hit, delta}.
    function automatic int unsigned ch_field_w(input int unsigned delta_w);
        return delta_w + 1;
    endfunction

    function automatic int unsigned ch_lsb(input int unsigned ts_w, input int unsigned delta_w,
                                           input int unsigned idx);
        return ts_w + idx * ch_field_w(delta_w);
    endfunction

endpackage

// File: rtl/tagger_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head word is valid one cycle after
// the push into an empty FIFO and reads as zero while empty.
module tagger_sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           din,
    output logic                   full,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign valid   = (cnt_q != '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & valid;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign level   = cnt_q;
    assign dout    = valid ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/tagger_evt_fifo.sv
// N-channel time tagger: synchronises channel/trigger pulses, builds one record per
// trigger edge (timestamp plus per-channel hit/delay) and queues it in an event FIFO.
module tagger_evt_fifo
    import tagger_pkg::*;
#(
    parameter int unsigned N_CH       = 3,
    parameter int unsigned TS_W       = 48,
    parameter int unsigned SCALER_W   = 32,
    parameter int unsigned DELTA_W    = 8,
    parameter int unsigned WINDOW     = 200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  ena_acq,
    input  logic                                  clr_cnt,
    input  logic [N_CH-1:0]                       ch_in,
    input  logic                                  trig,
    output logic                                  evt_valid,
    input  logic                                  evt_ready,
    output logic [TS_W+N_CH*(DELTA_W+1)-1:0]      evt_data,
    output logic [$clog2(FIFO_DEPTH):0]           fifo_level,
    output logic [LOST_W-1:0]                     lost_cnt,
    output logic [N_CH*SCALER_W-1:0]              ch_scalers,
    output logic [SCALER_W-1:0]                   trig_scaler,
    output logic [TS_W-1:0]                       timestamp
);

    localparam int unsigned FIELD_W = ch_field_w(DELTA_W);
    localparam int unsigned EVT_W   = TS_W + N_CH * FIELD_W;

    if (N_CH < 1 || N_CH > 8) begin : g_bad_n_ch
        $error("N_CH must be in 1..8");
    end
    if (WINDOW > 2**DELTA_W - 1) begin : g_bad_window
        $error("WINDOW does not fit in DELTA_W bits");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    // ------------------------------------------------------------------
    // Input synchronisers and rising-edge detect; trigger is the top bit.
    // ------------------------------------------------------------------
    logic [N_CH:0] raw_in;
    logic [N_CH:0] rise;

    assign raw_in = {trig, ch_in};

    for (genvar g = 0; g <= N_CH; g++) begin : g_sync
        logic [SYNC_DEPTH:0] sh_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sh_q <= '0;
            end else begin
                sh_q <= {sh_q[SYNC_DEPTH-1:0], raw_in[g]};
            end
        end

        assign rise[g] = sh_q[SYNC_DEPTH-1] & ~sh_q[SYNC_DEPTH];
    end

    logic [N_CH-1:0] ch_edge;
    logic            trig_edge;

    assign ch_edge   = rise[N_CH-1:0] & {N_CH{ena_acq}};
    assign trig_edge = rise[N_CH] & ena_acq;

    // ------------------------------------------------------------------
    // Free-running timestamp
    // ------------------------------------------------------------------
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign timestamp = ts_q;

    // ------------------------------------------------------------------
    // Per-channel latest-edge capture and record builder
    // ------------------------------------------------------------------
    logic [TS_W-1:0]  ch_ts_q [N_CH];
    logic [N_CH-1:0]  seen_q;
    logic [TS_W-1:0]  delta [N_CH];
    logic [N_CH-1:0]  hit;
    logic [EVT_W-1:0] rec_d;
    logic [EVT_W-1:0] rec_q;
    logic             rec_vld_q;

    always_comb begin
        rec_d                    = '0;
        hit                      = '0;
        rec_d[TS_LSB +: TS_W]    = ts_q;
        for (int i = 0; i < N_CH; i++) begin
            // An edge coinciding with the trigger is taken as a zero-delay hit.
            delta[i] = ch_edge[i] ? '0 : (ts_q - ch_ts_q[i]);
            hit[i]   = ch_edge[i] | (seen_q[i] & (delta[i] <= TS_W'(WINDOW)));
            if (hit[i]) begin
                rec_d[ch_lsb(TS_W, DELTA_W, i) +: FIELD_W] = {1'b1, delta[i][DELTA_W-1:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                ch_ts_q[i] <= '0;
            end
            seen_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_edge[i]) begin
                    ch_ts_q[i] <= ts_q;
                end
                if (trig_edge && hit[i]) begin
                    seen_q[i] <= 1'b0;
                end else if (ch_edge[i]) begin
                    seen_q[i] <= 1'b1;
                end
            end
        end
    end

    // Record stage runs independently of ena_acq so an in-flight record is still pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_q     <= '0;
            rec_vld_q <= 1'b0;
        end else begin
            rec_vld_q <= trig_edge;
            if (trig_edge) begin
                rec_q <= rec_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic fifo_full;
    logic drop;

    tagger_sync_fifo #(
        .W     (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rec_vld_q),
        .din   (rec_q),
        .full  (fifo_full),
        .pop   (evt_ready),
        .dout  (evt_data),
        .valid (evt_valid),
        .level (fifo_level)
    );

    // Full implies the head is valid, so evt_ready alone tells whether a slot frees up.
    assign drop = rec_vld_q & fifo_full & ~evt_ready;

    // ------------------------------------------------------------------
    // Scalers and lost counter; clear takes priority over counting.
    // ------------------------------------------------------------------
    logic [SCALER_W-1:0] ch_cnt_q [N_CH];
    logic [SCALER_W-1:0] trig_cnt_q;
    logic [LOST_W-1:0]   lost_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                ch_cnt_q[i] <= '0;
            end
            trig_cnt_q <= '0;
            lost_q     <= '0;
        end else if (clr_cnt) begin
            for (int i = 0; i < N_CH; i++) begin
                ch_cnt_q[i] <= '0;
            end
            trig_cnt_q <= '0;
            lost_q     <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_edge[i]) begin
                    ch_cnt_q[i] <= ch_cnt_q[i] + SCALER_W'(1);
                end
            end
            if (trig_edge) begin
                trig_cnt_q <= trig_cnt_q + SCALER_W'(1);
            end
            if (drop && lost_q != '1) begin
                lost_q <= lost_q + LOST_W'(1);
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_scaler_out
        assign ch_scalers[g*SCALER_W +: SCALER_W] = ch_cnt_q[g];
    end

    assign trig_scaler = trig_cnt_q;
    assign lost_cnt    = lost_q;

endmodule
